// File: rtl/ctl_pkg.sv
// ctl_pkg: shared types and constants for the hardwired control sequencer.
//   - state_e : sequencer states (IDLE while clear is held, F0-F2 fetch,
//               T3-T7 execute, HALT park state)
//   - iclass_e: instruction classes produced by instr_decode
//   - opcode constants, ALU_ADD, and IR field bit positions
// Optional feature macro used by the files importing this package: MULDIV_EN.
package ctl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F0   = 4'd1,
    ST_F1   = 4'd2,
    ST_F2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LD     = 3'd1,
    CLS_ST     = 3'd2,
    CLS_MULDIV = 3'd3,
    CLS_NOP    = 3'd4,
    CLS_HALT   = 3'd5
  } iclass_e;

  localparam logic [4:0] OP_ALU_MAX = 5'd12;
  localparam logic [4:0] OP_LD      = 5'd13;
  localparam logic [4:0] OP_ST      = 5'd14;
  localparam logic [4:0] OP_MUL     = 5'd15;
  localparam logic [4:0] OP_DIV     = 5'd16;
  localparam logic [4:0] OP_NOP     = 5'd26;
  localparam logic [4:0] OP_HALT    = 5'd27;

  localparam logic [4:0] ALU_ADD    = 5'd3;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational instruction decoder.
// Ports:
//   ir_i      in  32 : current IR contents
//   iclass_o  out 3  : instruction class (ctl_pkg::iclass_e encoding)
//   ra_o/rb_o/rc_o out 4 : register fields
//   op_o      out 5  : raw opcode field
// Macro MULDIV_EN: when undefined, opcodes 15/16 are classified as nop.
module instr_decode
  import ctl_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [2:0]  iclass_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [3:0]  rc_o,
  output logic [4:0]  op_o
);

  logic [4:0] op_s;
  // The constant field C is consumed by the datapath (Cout), not by the sequencer.
  logic       unused_c_bits_s;

  assign op_s = ir_i[OPC_MSB:OPC_LSB];
  assign op_o = op_s;
  assign ra_o = ir_i[RA_MSB:RA_LSB];
  assign rb_o = ir_i[RB_MSB:RB_LSB];
  assign rc_o = ir_i[RC_MSB:RC_LSB];
  assign unused_c_bits_s = ^ir_i[RC_LSB-1:C_LSB];

  // Opcode to instruction class; anything not recognised behaves as nop.
  always_comb begin
    iclass_o = CLS_NOP;
    if (op_s <= OP_ALU_MAX) begin
      iclass_o = CLS_ALU;
    end else begin
      case (op_s)
        OP_LD:   iclass_o = CLS_LD;
        OP_ST:   iclass_o = CLS_ST;
        OP_MUL,
        OP_DIV: begin
`ifdef MULDIV_EN
          iclass_o = CLS_MULDIV;
`else
          iclass_o = CLS_NOP;
`endif
        end
        OP_HALT: iclass_o = CLS_HALT;
        OP_NOP:  iclass_o = CLS_NOP;
        default: iclass_o = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore control sequencer for the 32-bit bus datapath.
// Fetches (F0-F2), decodes IR and steps through T3-T7 driving datapath strobes.
// Ports:
//   clock, clear (async, active-high), ir[31:0]
//   reg_in_en/reg_in_sel[3:0], reg_out_en/reg_out_sel[3:0] : register file selects
//   PCout PCin IncPC MARin MDRin MDRout IRin Yin Zin Zhighout Zlowout HIin LOin
//   Cout, read, write, opcode[4:0] (ALU op), run (low while reset or halted)
// Macro MULDIV_EN: enables the 7-cycle mul/div HI/LO sequence; when undefined
// HIin, LOin and Zhighout are never asserted.
module control_unit
  import ctl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  output logic        reg_in_en,
  output logic [3:0]  reg_in_sel,
  output logic        reg_out_en,
  output logic [3:0]  reg_out_sel,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        Cout,
  output logic        read,
  output logic        write,
  output logic [4:0]  opcode,
  output logic        run
);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] cls_s;
  logic [3:0] ra_s;
  logic [3:0] rb_s;
  logic [3:0] rc_s;
  logic [4:0] op_s;

  instr_decode u_decode (
    .ir_i     (ir),
    .iclass_o (cls_s),
    .ra_o     (ra_s),
    .rb_o     (rb_s),
    .rc_o     (rc_s),
    .op_o     (op_s)
  );

  // State register; clear parks the sequencer in IDLE so every output drops at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; instruction length is chosen by class at F2, T5 and T6.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2: begin
        case (cls_s)
          CLS_ALU, CLS_LD, CLS_ST, CLS_MULDIV: state_d = ST_T3;
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_F0;
        endcase
      end
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        case (cls_s)
          CLS_LD, CLS_ST, CLS_MULDIV: state_d = ST_T6;
          default: state_d = ST_F0;
        endcase
      end
      ST_T6: begin
        case (cls_s)
          CLS_LD, CLS_ST: state_d = ST_T7;
          default: state_d = ST_F0;
        endcase
      end
      ST_T7:   state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from state and IR class; anything not set stays 0.
  always_comb begin
    reg_in_en   = 1'b0;
    reg_in_sel  = 4'd0;
    reg_out_en  = 1'b0;
    reg_out_sel = 4'd0;
    PCout       = 1'b0;
    PCin        = 1'b0;
    IncPC       = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    Zhighout    = 1'b0;
    Zlowout     = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Cout        = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    opcode      = 5'd0;
    run         = 1'b0;
    case (state_q)
      ST_F0: begin
        run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_F1: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_F2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        run         = 1'b1;
        reg_out_en  = 1'b1;
        reg_out_sel = rb_s;
        Yin         = 1'b1;
      end
      ST_T4: begin
        run = 1'b1;
        Zin = 1'b1;
        case (cls_s)
          CLS_ALU, CLS_MULDIV: begin
            reg_out_en  = 1'b1;
            reg_out_sel = rc_s;
            opcode      = op_s;
          end
          CLS_LD, CLS_ST: begin
            Cout   = 1'b1;
            opcode = ALU_ADD;
          end
          default: opcode = 5'd0;
        endcase
      end
      ST_T5: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        case (cls_s)
          CLS_ALU: begin
            reg_in_en  = 1'b1;
            reg_in_sel = ra_s;
          end
          CLS_LD, CLS_ST: MARin = 1'b1;
`ifdef MULDIV_EN
          CLS_MULDIV: LOin = 1'b1;
`else
`endif
          default: MARin = 1'b0;
        endcase
      end
      ST_T6: begin
        run = 1'b1;
        case (cls_s)
          CLS_LD: begin
            read  = 1'b1;
            MDRin = 1'b1;
          end
          CLS_ST: begin
            // read stays 0 so MDR takes the bus (Ra) rather than memory.
            reg_out_en  = 1'b1;
            reg_out_sel = ra_s;
            MDRin       = 1'b1;
          end
`ifdef MULDIV_EN
          CLS_MULDIV: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
`else
`endif
          default: MDRin = 1'b0;
        endcase
      end
      ST_T7: begin
        run = 1'b1;
        case (cls_s)
          CLS_LD: begin
            MDRout     = 1'b1;
            reg_in_en  = 1'b1;
            reg_in_sel = ra_s;
          end
          CLS_ST:  write = 1'b1;
          default: write = 1'b0;
        endcase
      end
      ST_IDLE: run = 1'b0;
      ST_HALT: run = 1'b0;
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. A behavioural model turns
// each IR word into its list of per-cycle control vectors; the stimulus process
// queues those, and a negedge monitor compares the DUT against the queue.
// Honours MULDIV_EN the same way as the design.
module tb_control_unit;

  typedef struct packed {
    logic       rin_en;
    logic [3:0] rin_sel;
    logic       rout_en;
    logic [3:0] rout_sel;
    logic       PCout;
    logic       PCin;
    logic       IncPC;
    logic       MARin;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       Yin;
    logic       Zin;
    logic       Zhighout;
    logic       Zlowout;
    logic       HIin;
    logic       LOin;
    logic       Cout;
    logic       read;
    logic       write;
    logic [4:0] opcode;
    logic       run;
  } ctl_t;

  typedef struct {
    ctl_t  vec;
    string tag;
    int    idx;
  } exp_t;

`ifdef MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  logic        clk;
  logic        clear;
  logic [31:0] ir;
  logic        reg_in_en, reg_out_en;
  logic [3:0]  reg_in_sel, reg_out_sel;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic        Zhighout, Zlowout, HIin, LOin, Cout, read, write, run;
  logic [4:0]  opcode;

  ctl_t act;
  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  control_unit dut (
    .clock(clk), .clear(clear), .ir(ir),
    .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
    .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .Cout(Cout), .read(read),
    .write(write), .opcode(opcode), .run(run)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always_comb begin
    act = '0;
    act.rin_en = reg_in_en;     act.rin_sel = reg_in_sel;
    act.rout_en = reg_out_en;   act.rout_sel = reg_out_sel;
    act.PCout = PCout;   act.PCin = PCin;       act.IncPC = IncPC;
    act.MARin = MARin;   act.MDRin = MDRin;     act.MDRout = MDRout;
    act.IRin = IRin;     act.Yin = Yin;         act.Zin = Zin;
    act.Zhighout = Zhighout; act.Zlowout = Zlowout;
    act.HIin = HIin;     act.LOin = LOin;       act.Cout = Cout;
    act.read = read;     act.write = write;     act.opcode = opcode;
    act.run = run;
  end

  // Monitor: one expected vector per clock cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.vec) begin
        fails++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, e.idx, act, e.vec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input int op, input int ra, input int rb,
                                     input int rc, input int c);
    logic [4:0]  o5 = op[4:0];
    logic [3:0]  a4 = ra[3:0];
    logic [3:0]  b4 = rb[3:0];
    logic [3:0]  c4 = rc[3:0];
    logic [14:0] k15 = c[14:0];
    return {o5, a4, b4, c4, k15};
  endfunction

  // Reference: the register-transfer steps each instruction needs, cycle by cycle.
  task automatic run_instr(input logic [31:0] i, input int abort_at);
    ctl_t seq[$];
    ctl_t v;
    int op = int'(i[31:27]);
    logic [3:0] ra = i[26:23];
    logic [3:0] rb = i[22:19];
    logic [3:0] rc = i[18:15];
    int n;
    string tag = $sformatf("op%0d_ir%h", op, i);
    v = '0; v.run = 1; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; seq.push_back(v);
    v = '0; v.run = 1; v.Zlowout = 1; v.PCin = 1; v.read = 1; v.MDRin = 1; seq.push_back(v);
    v = '0; v.run = 1; v.MDRout = 1; v.IRin = 1; seq.push_back(v);
    if (op <= 12 || op == 13 || op == 14 || (MULDIV_ON && (op == 15 || op == 16))) begin
      v = '0; v.run = 1; v.rout_en = 1; v.rout_sel = rb; v.Yin = 1; seq.push_back(v);
      v = '0; v.run = 1; v.Zin = 1;
      if (op == 13 || op == 14) begin
        v.Cout = 1; v.opcode = 5'd3;
      end else begin
        v.rout_en = 1; v.rout_sel = rc; v.opcode = op[4:0];
      end
      seq.push_back(v);
      v = '0; v.run = 1; v.Zlowout = 1;
      if (op <= 12) begin v.rin_en = 1; v.rin_sel = ra; end
      else if (op == 13 || op == 14) v.MARin = 1;
      else v.LOin = 1;
      seq.push_back(v);
      if (op == 13) begin
        v = '0; v.run = 1; v.read = 1; v.MDRin = 1; seq.push_back(v);
        v = '0; v.run = 1; v.MDRout = 1; v.rin_en = 1; v.rin_sel = ra; seq.push_back(v);
      end else if (op == 14) begin
        v = '0; v.run = 1; v.rout_en = 1; v.rout_sel = ra; v.MDRin = 1; seq.push_back(v);
        v = '0; v.run = 1; v.write = 1; seq.push_back(v);
      end else if (op == 15 || op == 16) begin
        v = '0; v.run = 1; v.Zhighout = 1; v.HIin = 1; seq.push_back(v);
      end
    end
    ir = i;
    n = (abort_at >= 0 && abort_at < seq.size()) ? abort_at : seq.size();
    for (int k = 0; k < n; k++) exp_q.push_back('{vec: seq[k], tag: tag, idx: k});
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      exp_q.push_back('{vec: ctl_t'(0), tag: tag, idx: k});
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse clear mid-cycle: outputs must drop before any clock edge.
  task automatic clear_pulse(input string tag);
    clear = 1'b1;
    #1;
    checks++;
    if (act !== ctl_t'(0)) begin
      fails++;
      $display("FAIL %s_async: got %h expected %h", tag, act, ctl_t'(0));
    end
    exp_q.push_back('{vec: ctl_t'(0), tag: tag, idx: 0});
    #1;
    clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int op;
    clear = 1'b0;
    ir    = 32'd0;
    #5;
    clear = 1'b1;
    #1;
    checks++;
    if (act !== ctl_t'(0)) begin
      fails++;
      $display("FAIL reset_async: got %h expected %h", act, ctl_t'(0));
    end
    @(posedge clk); #1;
    exp_q.push_back('{vec: ctl_t'(0), tag: "reset_held", idx: 0});
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.push_back('{vec: ctl_t'(0), tag: "reset_release", idx: 0});
    @(posedge clk); #1;

    run_instr(mk(5, 4, 3, 7, 0), -1);
    run_instr(32'h6888_0010, -1);
    run_instr(mk(14, 2, 5, 0, 8), -1);
    run_instr(mk(15, 3, 1, 2, 0), -1);
    run_instr(mk(16, 6, 9, 10, 0), -1);
    run_instr(mk(26, 1, 2, 3, 0), -1);
    run_instr(mk(31, 15, 15, 15, 0), -1);
    run_instr(mk(0, 15, 0, 15, 0), -1);
    run_instr(mk(12, 0, 15, 1, 0), -1);

    for (int n = 0; n < 50; n++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      run_instr(mk(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 32767))), -1);
    end

    run_instr(mk(14, 2, 4, 0, 3), 6);
    clear_pulse("st_abort_T6");
    run_instr(mk(1, 5, 6, 7, 0), -1);

    run_instr(mk(27, 0, 0, 0, 0), -1);
    expect_idle("halt_park", 10);
    clear_pulse("halt_clear");
    run_instr(mk(13, 3, 2, 0, 4), -1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
